// File: rtl/pkg_maquina.sv
// Shared definitions for the candy-machine input path and its FSM.
// Latency: none (type and constant definitions only).
// Backpressure: not applicable.
package pkg_maquina;

    // Debounce FSM states. All four 2-bit codes are in use.
    typedef enum logic [1:0] {
        SOLTO          = 2'b00,
        CONFIRMA_PRESS = 2'b01,
        PRESSIONADO    = 2'b10,
        CONFIRMA_SOLTA = 2'b11
    } estado_t;

    // Default debounce window in clk cycles. Board-top timing uses the same value.
    localparam int DEBOUNCE_CYCLES_DEF = 50000;

endpackage

// File: rtl/sincronizador.sv
// Purpose: STAGES-deep flip-flop chain that brings an asynchronous level into the clk domain.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; the chain samples d on every edge.
// Ports: clk, reset (async, active-low), d (async level in), q (synchronised level out).
module sincronizador #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // The stages are a plain shift register. Any logic between stages would
    // weaken the metastability protection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/condicionador_entrada.sv
// Purpose: synchronise and debounce a bouncy pin; emit one x_pulse per confirmed press.
// Latency: x_pulse follows SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges after raw_in first samples high.
// Backpressure: none; x_pulse is a fire-and-forget single-cycle strobe.
// Ports: clk, reset (async, active-low), raw_in (async pin level),
//        x_pulse (one cycle per press), level (debounced, 1 = pressed), busy (change being confirmed).
module condicionador_entrada
    import pkg_maquina::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic x_pulse,
    output logic level,
    output logic busy
);

    logic             s_in;
    estado_t          state;
    estado_t          state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pulse_nxt;
    logic             level_nxt;
    logic             busy_nxt;

    sincronizador #(
        .STAGES (SYNC_STAGES)
    ) u_sinc (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (s_in)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SOLTO;
            cnt     <= '0;
            x_pulse <= 1'b0;
            level   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            x_pulse <= pulse_nxt;
            level   <= level_nxt;
            busy    <= busy_nxt;
        end
    end

    // cnt counts consecutive samples at the new level. The sample that leaves
    // SOLTO/PRESSIONADO counts as the first. The counter is cleared on every exit
    // from a confirm state, so it never reaches past DEBOUNCE_CYCLES.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        case (state)
            SOLTO: begin
                if (s_in) begin
                    state_nxt = CONFIRMA_PRESS;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            CONFIRMA_PRESS: begin
                if (!s_in) begin
                    state_nxt = SOLTO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_nxt = PRESSIONADO;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSIONADO: begin
                if (!s_in) begin
                    state_nxt = CONFIRMA_SOLTA;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            CONFIRMA_SOLTA: begin
                if (s_in) begin
                    state_nxt = PRESSIONADO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_nxt = SOLTO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = SOLTO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // level and busy are decoded from the next state. The registers then change
    // on the same edge as the state register instead of one cycle after it.
    always_comb begin
        level_nxt = (state_nxt == PRESSIONADO) || (state_nxt == CONFIRMA_SOLTA);
        busy_nxt  = (state_nxt == CONFIRMA_PRESS) || (state_nxt == CONFIRMA_SOLTA);
    end

endmodule

// File: tb/tb_condicionador_entrada.sv
module tb_condicionador_entrada;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic reset;
    logic raw_in;
    logic x_pulse;
    logic level;
    logic busy;

    always #5 clk = ~clk;

    condicionador_entrada #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .raw_in  (raw_in),
        .x_pulse (x_pulse),
        .level   (level),
        .busy    (busy)
    );

    int n_chk = 0;
    int n_ok  = 0;

    // Reference model: s_in is raw_in delayed by SYNC edges. A level change is
    // accepted once the delayed input has differed from the accepted level on
    // DEB + 1 consecutive edges: DEB counted samples plus the confirming one.
    bit q_hist[$];
    bit m_level;
    int m_run;
    bit m_pulse;
    bit m_busy;
    int m_pulses = 0;
    int d_pulses = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void m_reset();
        q_hist = {};
        for (int i = 0; i < SYNC; i++) q_hist.push_back(1'b0);
        m_level = 1'b0;
        m_run   = 0;
        m_pulse = 1'b0;
        m_busy  = 1'b0;
    endfunction

    function automatic void m_edge(input bit r);
        bit v;
        v = q_hist.pop_front();
        q_hist.push_back(r);
        m_pulse = 1'b0;
        if (v != m_level) begin
            m_run++;
            if (m_run == DEB + 1) begin
                m_level = v;
                m_run   = 0;
                if (v) begin
                    m_pulse = 1'b1;
                    m_pulses++;
                end
            end
        end else begin
            m_run = 0;
        end
        m_busy = (m_run != 0);
    endfunction

    // Drive on the falling edge, advance the model on the rising edge,
    // compare 1 time unit later.
    task automatic tick(input bit r, input bit rst);
        @(negedge clk);
        raw_in = r;
        reset  = rst;
        @(posedge clk);
        if (!rst) m_reset();
        else m_edge(r);
        #1;
        chk("x_pulse", int'(x_pulse), int'(m_pulse));
        chk("level", int'(level), int'(m_level));
        chk("busy", int'(busy), int'(m_busy));
        if (x_pulse) d_pulses++;
    endtask

    int first;
    int p0;
    int nbusy;
    bit rv;
    int len;
    bit bounce_pat[10];

    initial begin
        reset  = 1'b0;
        raw_in = 1'b0;
        m_reset();

        // Reset held low while raw_in toggles; outputs must stay 0.
        for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
        chk("idle_level", int'(level), 0);

        // Clean press: pulse on the 7th edge after raw_in first samples high.
        p0 = d_pulses; first = -1; nbusy = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b1);
            if (x_pulse && first < 0) first = i;
            if (busy) nbusy++;
        end
        chk("press_latency", first, SYNC + DEB + 1);
        chk("press_busy_cycles", nbusy, DEB);
        chk("press_pulses", d_pulses - p0, 1);
        chk("press_level", int'(level), 1);

        // Clean release: level drops and no pulse is produced.
        p0 = d_pulses;
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);
        chk("release_level", int'(level), 0);
        chk("release_pulses", d_pulses - p0, 0);

        // Press with bounce: exactly one pulse.
        bounce_pat = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
        p0 = d_pulses;
        for (int i = 0; i < 25; i++) tick((i < 10) ? bounce_pat[i] : 1'b1, 1'b1);
        chk("bounce_pulses", d_pulses - p0, 1);
        chk("bounce_level", int'(level), 1);

        // Release with bounce: level returns to 0 with no pulse.
        p0 = d_pulses;
        for (int i = 0; i < 25; i++) tick((i < 10) ? ~bounce_pat[i] : 1'b0, 1'b1);
        chk("bounce_rel_level", int'(level), 0);
        chk("bounce_rel_pulses", d_pulses - p0, 0);

        // Glitch of 3 high cycles: ignored.
        p0 = d_pulses;
        for (int i = 0; i < 18; i++) tick((i < 3) ? 1'b1 : 1'b0, 1'b1);
        chk("glitch_pulses", d_pulses - p0, 0);
        chk("glitch_level", int'(level), 0);
        chk("glitch_busy", int'(busy), 0);

        // Async reset while confirming a press; input held high across reset.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        chk("pre_rst_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_pulse", int'(x_pulse), 0);
        chk("async_rst_level", int'(level), 0);
        chk("async_rst_busy", int'(busy), 0);
        m_reset();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        p0 = d_pulses; first = -1;
        for (int i = 1; i <= 14; i++) begin
            tick(1'b1, 1'b1);
            if (x_pulse && first < 0) first = i;
        end
        chk("post_rst_latency", first, SYNC + DEB + 1);
        chk("post_rst_pulses", d_pulses - p0, 1);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);

        // Random runs of mixed lengths with occasional resets.
        rv = 1'b0;
        for (int k = 0; k < 400; k++) begin
            rv  = ~rv;
            len = $urandom_range(1, 10);
            for (int j = 0; j < len; j++) tick(rv, ($urandom_range(0, 199) != 0));
        end
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);
        chk("pulse_total", d_pulses, m_pulses);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
